// File: rtl/alu_sliced.sv
// alu_sliced: multi-cycle ALU that evaluates a WIDTH-bit add/sub/logic op SLICE bits per cycle.
// Latency: out_valid rises NSLICE cycles after the accept edge; one operation in flight at a time.
// Backpressure: result and flags hold in DONE until out_ready; in_ready is high only when IDLE.
//
// Ports:
//   clk, reset_n            clock and synchronous active-low reset
//   in_valid / in_ready     request handshake; a, b, control sampled on accept only
//   out_valid / out_ready   result handshake; result and flags stable while out_valid
//   result, negative, zero, overflow, carry_out   operation result and status flags
//
// control: 000 B, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 A^B, 001/111 zero.

module alu_sliced #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SMASK    = WIDTH'({SLICE{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0]       ctrl_r;
    logic             carry_r;

    logic [31:0]      base;
    logic [SLICE-1:0] a_s, b_s, bop, slice_res;
    logic [SLICE:0]   sum;
    logic             cin, is_arith, is_last, msb_cin;
    logic [WIDTH-1:0] res_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Slice datapath: the only combinational carry chain is SLICE bits long.
    always_comb begin
        base      = 32'(idx) * 32'(SLICE);
        a_s       = SLICE'(a_r >> base);
        b_s       = SLICE'(b_r >> base);
        is_arith  = (ctrl_r == 3'b010) || (ctrl_r == 3'b011);
        is_last   = (idx == LAST_IDX);
        // Subtract is A + ~B + 1: control[0] both selects the inversion and
        // supplies the +1 as the carry-in of slice 0.
        bop       = ctrl_r[0] ? ~b_s : b_s;
        cin       = (idx == '0) ? ctrl_r[0] : carry_r;
        sum       = {1'b0, a_s} + {1'b0, bop} + {{SLICE{1'b0}}, cin};
        // Carry into the top bit of the slice, recovered from the sum bit.
        msb_cin   = a_s[SLICE-1] ^ bop[SLICE-1] ^ sum[SLICE-1];
        slice_res = '0;
        case (ctrl_r)
            3'b000:         slice_res = b_s;
            3'b010, 3'b011: slice_res = sum[SLICE-1:0];
            3'b100:         slice_res = a_s & b_s;
            3'b101:         slice_res = a_s | b_s;
            3'b110:         slice_res = a_s ^ b_s;
            default:        slice_res = '0;
        endcase
        res_nxt = (result & ~(SMASK << base)) | (WIDTH'(slice_res) << base);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (is_last)   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            ctrl_r    <= '0;
            carry_r   <= 1'b0;
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        ctrl_r <= control;
                        idx    <= '0;
                    end
                end
                BUSY: begin
                    result  <= res_nxt;
                    carry_r <= sum[SLICE];
                    if (is_last) begin
                        idx       <= '0;
                        negative  <= slice_res[SLICE-1];
                        zero      <= (res_nxt == '0);
                        carry_out <= is_arith & sum[SLICE];
                        overflow  <= is_arith & (msb_cin ^ sum[SLICE]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
